// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared widths, encodings and entry layout for the hazard/forwarding unit
package hazard_pkg;

    localparam int TW = 2;

    localparam logic [TW-1:0] TUSE_D = 2'd0;
    localparam logic [TW-1:0] TUSE_E = 2'd1;
    localparam logic [TW-1:0] TUSE_M = 2'd2;

    // Stage entry is {wa, tnew}: tnew in the low TW bits, wa directly above.
    localparam int ENT_TNEW_LSB = 0;
    localparam int ENT_WA_LSB   = TW;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic [1:0] {
        SEL_RF,
        SEL_E,
        SEL_M,
        SEL_W
    } fwd_sel_e;

    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_port.sv
// rtl/hazard_fwd_unit_fwd_port.sv - per-read-port nearest-match select and stall request
module fwd_port
    import hazard_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] ra_i,
    input  logic [TW-1:0] tuse_i,
    input  logic [DW-1:0] rd_data_i,
    input  logic [AW-1:0] e_wa_i,
    input  logic [TW-1:0] e_tnew_i,
    input  logic [AW-1:0] m_wa_i,
    input  logic [TW-1:0] m_tnew_i,
    input  logic [AW-1:0] w_wa_i,
    input  logic [TW-1:0] w_tnew_i,
    input  logic [DW-1:0] e_out_i,
    input  logic [DW-1:0] m_out_i,
    input  logic [DW-1:0] w_out_i,
    output logic [DW-1:0] fwd_data_o,
    output logic          stall_req_o
);

    fwd_sel_e      sel;
    logic          hit;
    logic [TW-1:0] hit_tnew;

    // Youngest matching stage wins; a not-yet-ready match still shadows older ones.
    always_comb begin
        sel      = SEL_RF;
        hit      = 1'b0;
        hit_tnew = '0;
        if (ra_i != '0) begin
            if (e_wa_i == ra_i) begin
                hit      = 1'b1;
                hit_tnew = e_tnew_i;
                sel      = (e_tnew_i == '0) ? SEL_E : SEL_RF;
            end else if (m_wa_i == ra_i) begin
                hit      = 1'b1;
                hit_tnew = m_tnew_i;
                sel      = (m_tnew_i == '0) ? SEL_M : SEL_RF;
            end else if (w_wa_i == ra_i) begin
                hit      = 1'b1;
                hit_tnew = w_tnew_i;
                sel      = (w_tnew_i == '0) ? SEL_W : SEL_RF;
            end
        end
    end

    always_comb begin
        fwd_data_o = rd_data_i;
        case (sel)
            SEL_E:   fwd_data_o = e_out_i;
            SEL_M:   fwd_data_o = m_out_i;
            SEL_W:   fwd_data_o = w_out_i;
            default: fwd_data_o = rd_data_i;
        endcase
    end

    assign stall_req_o = hit && (hit_tnew > tuse_i);

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - E/M/W destination tracking, operand forwarding, stall and HI/LO busy counter
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int NREAD    = 2,
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREAD*AW-1:0] D_ra,
    input  logic [NREAD*TW-1:0] D_tuse,
    input  logic [NREAD*DW-1:0] D_rd_data,
    input  logic [AW-1:0]       D_wa,
    input  logic [TW-1:0]       D_tnew,
    input  logic                D_md,
    input  logic                D_md_start,
    input  logic                D_md_div,
    input  logic [DW-1:0]       E_out,
    input  logic [DW-1:0]       M_out,
    input  logic [DW-1:0]       W_out,
    output logic [NREAD*DW-1:0] D_fwd_data,
    output logic                stall,
    output logic                md_busy
);

    localparam int EW     = AW + TW;
    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [EW-1:0]    e_q, e_d, m_q, m_d, w_q, w_d;
    logic [CW-1:0]    md_cnt_q, md_cnt_d;
    logic [NREAD-1:0] port_stall;
    logic             data_stall;
    logic             md_stall;

    logic [AW-1:0] e_wa, m_wa, w_wa;
    logic [TW-1:0] e_tnew, m_tnew, w_tnew;

    assign e_wa   = e_q[ENT_WA_LSB +: AW];
    assign m_wa   = m_q[ENT_WA_LSB +: AW];
    assign w_wa   = w_q[ENT_WA_LSB +: AW];
    assign e_tnew = e_q[ENT_TNEW_LSB +: TW];
    assign m_tnew = m_q[ENT_TNEW_LSB +: TW];
    assign w_tnew = w_q[ENT_TNEW_LSB +: TW];

    for (genvar g = 0; g < NREAD; g++) begin : g_port
        fwd_port #(
            .DW(DW),
            .AW(AW)
        ) u_fwd_port (
            .ra_i        (D_ra[g*AW +: AW]),
            .tuse_i      (D_tuse[g*TW +: TW]),
            .rd_data_i   (D_rd_data[g*DW +: DW]),
            .e_wa_i      (e_wa),
            .e_tnew_i    (e_tnew),
            .m_wa_i      (m_wa),
            .m_tnew_i    (m_tnew),
            .w_wa_i      (w_wa),
            .w_tnew_i    (w_tnew),
            .e_out_i     (E_out),
            .m_out_i     (M_out),
            .w_out_i     (W_out),
            .fwd_data_o  (D_fwd_data[g*DW +: DW]),
            .stall_req_o (port_stall[g])
        );
    end

    assign md_busy    = (md_cnt_q != '0);
    assign data_stall = |port_stall;
    assign md_stall   = D_md && md_busy;
    assign stall      = data_stall || md_stall;

    // A stalled D instruction becomes a bubble in E; older entries age by one cycle.
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d[ENT_WA_LSB +: AW]   = D_wa;
            e_d[ENT_TNEW_LSB +: TW] = D_tnew;
        end
        m_d = '0;
        m_d[ENT_WA_LSB +: AW]   = e_wa;
        m_d[ENT_TNEW_LSB +: TW] = tnew_dec(e_tnew);
        w_d = '0;
        w_d[ENT_WA_LSB +: AW]   = m_wa;
        w_d[ENT_TNEW_LSB +: TW] = tnew_dec(m_tnew);
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (D_md_start && !stall) begin
            md_cnt_d = D_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            md_cnt_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_q      <= w_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - scoreboard bench for hazard_fwd_unit (three read ports)
module tb_hazard_fwd_unit;
    import hazard_pkg::*;

    localparam int NREAD = 3;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREAD*AW-1:0] D_ra;
    logic [NREAD*TW-1:0] D_tuse;
    logic [NREAD*DW-1:0] D_rd_data;
    logic [AW-1:0]       D_wa;
    logic [TW-1:0]       D_tnew;
    logic                D_md, D_md_start, D_md_div;
    logic [DW-1:0]       E_out, M_out, W_out;
    logic [NREAD*DW-1:0] D_fwd_data;
    logic                stall, md_busy;

    logic [AW-1:0] ra_a   [NREAD];
    logic [TW-1:0] tuse_a [NREAD];
    logic [DW-1:0] rd_a   [NREAD];

    for (genvar g = 0; g < NREAD; g++) begin : g_pack
        assign D_ra[g*AW +: AW]      = ra_a[g];
        assign D_tuse[g*TW +: TW]    = tuse_a[g];
        assign D_rd_data[g*DW +: DW] = rd_a[g];
    end

    typedef struct packed {
        logic [NREAD*DW-1:0] fwd;
        logic                stall;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    hazard_fwd_unit #(
        .NREAD(NREAD),
        .DW(DW),
        .AW(AW),
        .MULT_CYC(MULT_CYC_DEF),
        .DIV_CYC(DIV_CYC_DEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D_ra       (D_ra),
        .D_tuse     (D_tuse),
        .D_rd_data  (D_rd_data),
        .D_wa       (D_wa),
        .D_tnew     (D_tnew),
        .D_md       (D_md),
        .D_md_start (D_md_start),
        .D_md_div   (D_md_div),
        .E_out      (E_out),
        .M_out      (M_out),
        .W_out      (W_out),
        .D_fwd_data (D_fwd_data),
        .stall      (stall),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    task automatic idle();
        D_wa       = '0;
        D_tnew     = '0;
        D_md       = 1'b0;
        D_md_start = 1'b0;
        D_md_div   = 1'b0;
        E_out      = 32'hE0E0_0001;
        M_out      = 32'hB0B0_0002;
        W_out      = 32'hC0C0_0003;
        for (int i = 0; i < NREAD; i++) begin
            ra_a[i]   = '0;
            tuse_a[i] = TUSE_M;
            rd_a[i]   = 32'hD000_0000 + 32'(i);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        idle();
        repeat (3) step();
    endtask

    function automatic logic [NREAD*DW-1:0] rd_vec();
        return {rd_a[2], rd_a[1], rd_a[0]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < NREAD; i++) ra_a[i] = AW'(i + 1);
        exp_q.push_back(exp_t'{fwd: rd_vec(), stall: 1'b0});
        #2;
        e = exp_q.pop_front();
        tests++;
        if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
            fails++;
            $display("FAIL reset_out: fwd=%h stall=%b expected fwd=%h stall=%b", D_fwd_data, stall, e.fwd, e.stall);
        end
        tests++;
        if (md_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: md_busy=%b expected 0", md_busy);
        end
    endtask

    task automatic test_alu_alu();
        flush();
        D_wa = 5'd8; D_tnew = 2'd0;
        step();
        idle();
        ra_a[0] = 5'd8; tuse_a[0] = TUSE_E; E_out = 32'h0000_1234;
        exp_q.push_back(exp_t'{fwd: {rd_a[2], rd_a[1], 32'h0000_1234}, stall: 1'b0});
        #2;
        e = exp_q.pop_front();
        tests++;
        if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
            fails++;
            $display("FAIL alu_alu: fwd=%h stall=%b expected fwd=%h stall=%b", D_fwd_data, stall, e.fwd, e.stall);
        end
    endtask

    task automatic test_load_use();
        flush();
        D_wa = 5'd9; D_tnew = 2'd2;
        step();
        idle();
        ra_a[1] = 5'd9; tuse_a[1] = TUSE_E;
        // E={9,2}: stall; then M={9,1}: raw read data, no stall; then W={9,0}: W_out
        exp_q.push_back(exp_t'{fwd: rd_vec(), stall: 1'b1});
        exp_q.push_back(exp_t'{fwd: rd_vec(), stall: 1'b0});
        exp_q.push_back(exp_t'{fwd: {rd_a[2], W_out, rd_a[0]}, stall: 1'b0});
        for (int c = 0; c < 3; c++) begin
            #2;
            e = exp_q.pop_front();
            tests++;
            if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
                fails++;
                $display("FAIL load_use[%0d]: fwd=%h stall=%b expected fwd=%h stall=%b", c, D_fwd_data, stall, e.fwd, e.stall);
            end
            step();
        end
    endtask

    task automatic test_load_branch();
        flush();
        D_wa = 5'd9; D_tnew = 2'd2;
        step();
        idle();
        ra_a[0] = 5'd9; tuse_a[0] = TUSE_D;
        exp_q.push_back(exp_t'{fwd: rd_vec(), stall: 1'b1});
        exp_q.push_back(exp_t'{fwd: rd_vec(), stall: 1'b1});
        exp_q.push_back(exp_t'{fwd: {rd_a[2], rd_a[1], W_out}, stall: 1'b0});
        for (int c = 0; c < 3; c++) begin
            #2;
            e = exp_q.pop_front();
            tests++;
            if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
                fails++;
                $display("FAIL load_branch[%0d]: fwd=%h stall=%b expected fwd=%h stall=%b", c, D_fwd_data, stall, e.fwd, e.stall);
            end
            step();
        end
    endtask

    task automatic test_m_forward();
        flush();
        D_wa = 5'd7; D_tnew = 2'd1;
        step();
        idle();
        step();
        ra_a[0] = 5'd7; tuse_a[0] = TUSE_E;
        exp_q.push_back(exp_t'{fwd: {rd_a[2], rd_a[1], M_out}, stall: 1'b0});
        #2;
        e = exp_q.pop_front();
        tests++;
        if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
            fails++;
            $display("FAIL m_forward: fwd=%h stall=%b expected fwd=%h stall=%b", D_fwd_data, stall, e.fwd, e.stall);
        end
    endtask

    task automatic test_priority();
        flush();
        D_wa = 5'd5; D_tnew = 2'd0;
        step();
        step();
        idle();
        ra_a[0] = 5'd5; E_out = 32'hA; M_out = 32'hB;
        ra_a[1] = 5'd0; rd_a[1] = 32'h0;
        exp_q.push_back(exp_t'{fwd: {rd_a[2], 32'h0, 32'hA}, stall: 1'b0});
        #2;
        e = exp_q.pop_front();
        tests++;
        if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
            fails++;
            $display("FAIL priority_em: fwd=%h stall=%b expected fwd=%h stall=%b", D_fwd_data, stall, e.fwd, e.stall);
        end
        // Younger E={5,2} must shadow a ready M={5,0}
        flush();
        D_wa = 5'd5; D_tnew = 2'd0;
        step();
        D_wa = 5'd5; D_tnew = 2'd2;
        step();
        idle();
        ra_a[0] = 5'd5; tuse_a[0] = TUSE_M;
        exp_q.push_back(exp_t'{fwd: rd_vec(), stall: 1'b0});
        #2;
        e = exp_q.pop_front();
        tests++;
        if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
            fails++;
            $display("FAIL priority_shadow: fwd=%h stall=%b expected fwd=%h stall=%b", D_fwd_data, stall, e.fwd, e.stall);
        end
        tuse_a[0] = TUSE_E;
        exp_q.push_back(exp_t'{fwd: rd_vec(), stall: 1'b1});
        #1;
        e = exp_q.pop_front();
        tests++;
        if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
            fails++;
            $display("FAIL priority_stall: fwd=%h stall=%b expected fwd=%h stall=%b", D_fwd_data, stall, e.fwd, e.stall);
        end
    endtask

    task automatic test_md();
        int n;
        flush();
        D_md = 1'b1; D_md_start = 1'b1; D_md_div = 1'b1;
        #2;
        tests++;
        if ({stall, md_busy} !== 2'b00) begin
            fails++;
            $display("FAIL div_accept: stall=%b md_busy=%b expected 0 0", stall, md_busy);
        end
        step();
        // A multiply start follows; it must wait out the divide without reloading the counter
        idle();
        D_md = 1'b1; D_md_start = 1'b1; D_md_div = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (!stall) break;
            if (c == 0) begin
                tests++;
                if (md_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL div_busy_rise: md_busy=%b expected 1", md_busy);
                end
            end
            n++;
            step();
        end
        tests++;
        if (n != DIV_CYC_DEF) begin
            fails++;
            $display("FAIL div_stall_cycles: got %0d expected %0d", n, DIV_CYC_DEF);
        end
        tests++;
        if (md_busy !== 1'b0) begin
            fails++;
            $display("FAIL div_busy_fall: md_busy=%b expected 0", md_busy);
        end
        step();
        idle();
        D_md = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (!stall) break;
            n++;
            step();
        end
        tests++;
        if (n != MULT_CYC_DEF) begin
            fails++;
            $display("FAIL mult_stall_cycles: got %0d expected %0d", n, MULT_CYC_DEF);
        end
        tests++;
        if (md_busy !== 1'b0) begin
            fails++;
            $display("FAIL mult_busy_fall: md_busy=%b expected 0", md_busy);
        end
    endtask

    task automatic test_reset_mid();
        flush();
        D_md = 1'b1; D_md_start = 1'b1; D_md_div = 1'b1;
        step();
        idle();
        repeat (3) step();
        D_wa = 5'd3; D_tnew = 2'd2;
        step();
        idle();
        D_md = 1'b1;
        #2;
        tests++;
        if ({stall, md_busy} !== 2'b11) begin
            fails++;
            $display("FAIL pre_reset: stall=%b md_busy=%b expected 1 1", stall, md_busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        D_md = 1'b1;
        ra_a[0] = 5'd3; tuse_a[0] = TUSE_D;
        exp_q.push_back(exp_t'{fwd: rd_vec(), stall: 1'b0});
        #2;
        e = exp_q.pop_front();
        tests++;
        if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
            fails++;
            $display("FAIL post_reset: fwd=%h stall=%b expected fwd=%h stall=%b", D_fwd_data, stall, e.fwd, e.stall);
        end
        tests++;
        if (md_busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_busy: md_busy=%b expected 0", md_busy);
        end
    endtask

    task automatic test_three_ports();
        flush();
        D_wa = 5'd3; step();
        D_wa = 5'd2; step();
        D_wa = 5'd1; step();
        idle();
        ra_a[0] = 5'd1; ra_a[1] = 5'd2; ra_a[2] = 5'd3;
        for (int i = 0; i < NREAD; i++) tuse_a[i] = TUSE_D;
        exp_q.push_back(exp_t'{fwd: {W_out, M_out, E_out}, stall: 1'b0});
        #2;
        e = exp_q.pop_front();
        tests++;
        if ({D_fwd_data, stall} !== {e.fwd, e.stall}) begin
            fails++;
            $display("FAIL three_ports: fwd=%h stall=%b expected fwd=%h stall=%b", D_fwd_data, stall, e.fwd, e.stall);
        end
    endtask

    initial begin
        test_reset();
        test_alu_alu();
        test_load_use();
        test_load_branch();
        test_m_forward();
        test_priority();
        test_md();
        test_reset_mid();
        test_three_ports();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
